// File: rtl/back_buffer_controller.sv
// Back-buffer sequencer: clears the off-screen buffer after each swap, then lends
// port B to the renderer until it reports the frame is drawn.
module back_buffer_controller #(
    parameter int                 H_ACTIVE    = 640,
    parameter int                 V_ACTIVE    = 480,
    parameter int                 PIXEL_W     = 12,
    parameter logic [PIXEL_W-1:0] CLEAR_COLOR = '0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               next_frame,
    input  logic               clear_enable,
    input  logic               draw_req,
    input  logic [9:0]         draw_x,
    input  logic [9:0]         draw_y,
    input  logic               draw_we,
    input  logic [PIXEL_W-1:0] draw_wdata,
    input  logic               draw_done,
    output logic               draw_grant,
    output logic [PIXEL_W-1:0] draw_rdata,
    output logic               draw_rvalid,
    output logic [9:0]         buf_x,
    output logic [9:0]         buf_y,
    output logic               buf_we,
    output logic [PIXEL_W-1:0] buf_wdata,
    input  logic [PIXEL_W-1:0] buf_rdata,
    output logic               render_complete,
    output logic [15:0]        frame_count
);

    typedef enum logic [1:0] {CLEAR, DRAW, DONE} state_t;

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    state_t     state_reg;
    logic [9:0] cx_reg;
    logic [9:0] cy_reg;
    logic       rd_pend_reg;

    logic       start_clear;
    logic       clearing;
    logic       accept;
    logic       take;
    logic [9:0] ix;
    logic [9:0] iy;
    logic       last_x;
    logic       last_y;

    // The swap cycle itself issues pixel (0,0), so the clear burst begins on
    // the very next cycle, just as it does after reset release.
    always_comb begin
        start_clear = (state_reg == DONE) && next_frame && clear_enable;
        clearing    = (state_reg == CLEAR) || start_clear;
        ix          = (state_reg == CLEAR) ? cx_reg : 10'd0;
        iy          = (state_reg == CLEAR) ? cy_reg : 10'd0;
        last_x      = (ix == X_LAST);
        last_y      = (iy == Y_LAST);
        accept      = (state_reg == DRAW) && draw_grant;
        take        = accept && draw_req;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= CLEAR;
            cx_reg          <= '0;
            cy_reg          <= '0;
            rd_pend_reg     <= 1'b0;
            draw_grant      <= 1'b0;
            draw_rdata      <= '0;
            draw_rvalid     <= 1'b0;
            buf_x           <= '0;
            buf_y           <= '0;
            buf_we          <= 1'b0;
            buf_wdata       <= '0;
            render_complete <= 1'b0;
            frame_count     <= '0;
        end else begin
            buf_we      <= 1'b0;
            rd_pend_reg <= take && !draw_we;
            draw_rvalid <= rd_pend_reg;
            if (rd_pend_reg) begin
                draw_rdata <= buf_rdata;
            end

            if (clearing) begin
                buf_x     <= ix;
                buf_y     <= iy;
                buf_we    <= 1'b1;
                buf_wdata <= CLEAR_COLOR;
                if (last_x) begin
                    cx_reg <= '0;
                    cy_reg <= last_y ? 10'd0 : iy + 10'd1;
                end else begin
                    cx_reg <= ix + 10'd1;
                    cy_reg <= iy;
                end
                state_reg <= (last_x && last_y) ? DRAW : CLEAR;
            end else if (take) begin
                buf_x     <= draw_x;
                buf_y     <= draw_y;
                buf_we    <= draw_we;
                buf_wdata <= draw_wdata;
            end

            case (state_reg)
                CLEAR: begin
                    draw_grant      <= 1'b0;
                    render_complete <= 1'b0;
                end
                DRAW: begin
                    // Grant lags entry into DRAW by a cycle after a clear, so the
                    // renderer never overlaps the final clear write.
                    if (accept && draw_done) begin
                        state_reg       <= DONE;
                        draw_grant      <= 1'b0;
                        render_complete <= 1'b1;
                    end else begin
                        draw_grant <= 1'b1;
                    end
                end
                DONE: begin
                    if (next_frame) begin
                        frame_count     <= frame_count + 16'd1;
                        render_complete <= 1'b0;
                        if (!clear_enable) begin
                            state_reg  <= DRAW;
                            draw_grant <= 1'b1;
                            cx_reg     <= '0;
                            cy_reg     <= '0;
                        end
                    end
                end
                default: state_reg <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_back_buffer_controller.sv
// Directed bench for back_buffer_controller with an 8x4 buffer and a
// combinational-read port B model.
module tb_back_buffer_controller;

    localparam int H = 8;
    localparam int V = 4;
    localparam int PW = 12;
    localparam logic [PW-1:0] CC = 12'h005;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          next_frame = 1'b0;
    logic          clear_enable = 1'b0;
    logic          draw_req = 1'b0;
    logic [9:0]    draw_x = '0;
    logic [9:0]    draw_y = '0;
    logic          draw_we = 1'b0;
    logic [PW-1:0] draw_wdata = '0;
    logic          draw_done = 1'b0;
    logic          draw_grant;
    logic [PW-1:0] draw_rdata;
    logic          draw_rvalid;
    logic [9:0]    buf_x;
    logic [9:0]    buf_y;
    logic          buf_we;
    logic [PW-1:0] buf_wdata;
    logic [PW-1:0] buf_rdata;
    logic          render_complete;
    logic [15:0]   frame_count;

    int errors = 0;
    int checks = 0;

    back_buffer_controller #(
        .H_ACTIVE(H), .V_ACTIVE(V), .PIXEL_W(PW), .CLEAR_COLOR(CC)
    ) dut (
        .clock(clock), .reset(reset), .next_frame(next_frame),
        .clear_enable(clear_enable), .draw_req(draw_req), .draw_x(draw_x),
        .draw_y(draw_y), .draw_we(draw_we), .draw_wdata(draw_wdata),
        .draw_done(draw_done), .draw_grant(draw_grant), .draw_rdata(draw_rdata),
        .draw_rvalid(draw_rvalid), .buf_x(buf_x), .buf_y(buf_y), .buf_we(buf_we),
        .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
        .render_complete(render_complete), .frame_count(frame_count)
    );

    always #5 clock = ~clock;

    // Port B model: write on the clock edge, read combinationally from address.
    logic [PW-1:0] mem [0:H*V-1];
    assign buf_rdata = mem[{buf_y[1:0], buf_x[2:0]}];
    always @(posedge clock) begin
        if (buf_we) mem[{buf_y[1:0], buf_x[2:0]}] <= buf_wdata;
    end
    initial begin
        for (int i = 0; i < H*V; i++) mem[i] <= 12'h777;
    end

    typedef struct packed {
        logic          req;
        logic          we;
        logic [9:0]    x;
        logic [9:0]    y;
        logic [PW-1:0] wd;
        logic          done;
        logic          nf;
        logic          ce;
        logic          e_we;
        logic [9:0]    e_x;
        logic [9:0]    e_y;
        logic [PW-1:0] e_wd;
        logic          e_grant;
        logic          e_rv;
        logic [PW-1:0] e_rd;
        logic          e_rc;
        logic [15:0]   e_fc;
    } vec_t;

    vec_t vecs [0:12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        draw_req = 1'b0; draw_we = 1'b0; draw_x = '0; draw_y = '0;
        draw_wdata = '0; draw_done = 1'b0; next_frame = 1'b0; clear_enable = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " buf_x"}, 32'(buf_x), 0);
        check({tag, " buf_y"}, 32'(buf_y), 0);
        check({tag, " buf_we"}, 32'(buf_we), 0);
        check({tag, " buf_wdata"}, 32'(buf_wdata), 0);
        check({tag, " draw_grant"}, 32'(draw_grant), 0);
        check({tag, " draw_rvalid"}, 32'(draw_rvalid), 0);
        check({tag, " draw_rdata"}, 32'(draw_rdata), 0);
        check({tag, " render_complete"}, 32'(render_complete), 0);
        check({tag, " frame_count"}, 32'(frame_count), 0);
    endtask

    // Observes n clear cycles; renderer and swap inputs are driven with junk
    // throughout, which must all be ignored.
    task automatic run_clear(input int n, input logic [15:0] fc_exp);
        int e0 = errors;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check("clear buf_we", 32'(buf_we), 1);
            check("clear buf_x", 32'(buf_x), i % H);
            check("clear buf_y", 32'(buf_y), i / H);
            check("clear buf_wdata", 32'(buf_wdata), 32'(CC));
            check("clear draw_grant", 32'(draw_grant), 0);
            check("clear render_complete", 32'(render_complete), 0);
            check("clear frame_count", 32'(frame_count), 32'(fc_exp));
            check("clear draw_rvalid", 32'(draw_rvalid), 0);
            if (i < n - 1) begin
                draw_req = 1'b1; draw_we = 1'b1; draw_x = 10'd6; draw_y = 10'd1;
                draw_wdata = 12'hBAD; draw_done = 1'b1;
                next_frame = i[0]; clear_enable = 1'b1;
            end else begin
                set_idle();
            end
        end
        if (n == H*V) begin
            @(negedge clock);
            check("post-clear buf_we", 32'(buf_we), 0);
            check("post-clear draw_grant", 32'(draw_grant), 1);
            check("post-clear frame_count", 32'(frame_count), 32'(fc_exp));
        end
        $display("clear run: %0d cycles observed, frame_count=%0d, new errors=%0d",
                 n, frame_count, errors - e0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //      req   we    x      y      wd       done  nf    ce      e_we  e_x    e_y    e_wd     gnt   rv    rd       rc    fc
        vecs[0]  = {1'b1,1'b1,10'd3,10'd2,12'h00A,1'b0,1'b1,1'b0,  1'b1,10'd3,10'd2,12'h00A,1'b1,1'b0,12'h000,1'b0,16'd0};
        vecs[1]  = {1'b1,1'b0,10'd3,10'd2,12'h000,1'b0,1'b0,1'b0,  1'b0,10'd3,10'd2,12'h000,1'b1,1'b0,12'h000,1'b0,16'd0};
        vecs[2]  = {1'b0,1'b0,10'd0,10'd0,12'h000,1'b0,1'b0,1'b0,  1'b0,10'd3,10'd2,12'h000,1'b1,1'b1,12'h00A,1'b0,16'd0};
        vecs[3]  = {1'b1,1'b1,10'd7,10'd3,12'h123,1'b0,1'b0,1'b0,  1'b1,10'd7,10'd3,12'h123,1'b1,1'b0,12'h00A,1'b0,16'd0};
        vecs[4]  = {1'b1,1'b0,10'd0,10'd0,12'h000,1'b0,1'b0,1'b0,  1'b0,10'd0,10'd0,12'h000,1'b1,1'b0,12'h00A,1'b0,16'd0};
        vecs[5]  = {1'b1,1'b0,10'd7,10'd3,12'h000,1'b0,1'b0,1'b0,  1'b0,10'd7,10'd3,12'h000,1'b1,1'b1,12'h005,1'b0,16'd0};
        vecs[6]  = {1'b1,1'b0,10'd3,10'd2,12'h000,1'b1,1'b0,1'b0,  1'b0,10'd3,10'd2,12'h000,1'b0,1'b1,12'h123,1'b1,16'd0};
        vecs[7]  = {1'b0,1'b0,10'd0,10'd0,12'h000,1'b0,1'b0,1'b0,  1'b0,10'd3,10'd2,12'h000,1'b0,1'b1,12'h00A,1'b1,16'd0};
        vecs[8]  = {1'b1,1'b1,10'd1,10'd1,12'hFFF,1'b0,1'b0,1'b0,  1'b0,10'd3,10'd2,12'h000,1'b0,1'b0,12'h00A,1'b1,16'd0};
        vecs[9]  = {1'b0,1'b0,10'd0,10'd0,12'h000,1'b0,1'b1,1'b0,  1'b0,10'd3,10'd2,12'h000,1'b1,1'b0,12'h00A,1'b0,16'd1};
        vecs[10] = {1'b1,1'b0,10'd1,10'd1,12'h000,1'b0,1'b0,1'b0,  1'b0,10'd1,10'd1,12'h000,1'b1,1'b0,12'h00A,1'b0,16'd1};
        vecs[11] = {1'b0,1'b0,10'd0,10'd0,12'h000,1'b1,1'b1,1'b1,  1'b0,10'd1,10'd1,12'h000,1'b0,1'b1,12'h005,1'b1,16'd1};
        vecs[12] = {1'b0,1'b0,10'd0,10'd0,12'h000,1'b0,1'b0,1'b0,  1'b0,10'd1,10'd1,12'h000,1'b0,1'b0,12'h005,1'b1,16'd1};

        // Reset values, then first clear after release.
        set_idle();
        repeat (2) @(negedge clock);
        check_reset_values("reset");
        $display("reset: outputs checked while reset held");
        reset = 1'b0;
        run_clear(H*V, 16'd0);

        // Draw traffic, completion, clear skip, simultaneous done/next_frame.
        for (int i = 0; i < 13; i++) begin
            draw_req = vecs[i].req; draw_we = vecs[i].we;
            draw_x = vecs[i].x; draw_y = vecs[i].y; draw_wdata = vecs[i].wd;
            draw_done = vecs[i].done; next_frame = vecs[i].nf;
            clear_enable = vecs[i].ce;
            @(negedge clock);
            check($sformatf("vec%0d buf_we", i), 32'(buf_we), 32'(vecs[i].e_we));
            check($sformatf("vec%0d buf_x", i), 32'(buf_x), 32'(vecs[i].e_x));
            check($sformatf("vec%0d buf_y", i), 32'(buf_y), 32'(vecs[i].e_y));
            check($sformatf("vec%0d buf_wdata", i), 32'(buf_wdata), 32'(vecs[i].e_wd));
            check($sformatf("vec%0d draw_grant", i), 32'(draw_grant), 32'(vecs[i].e_grant));
            check($sformatf("vec%0d draw_rvalid", i), 32'(draw_rvalid), 32'(vecs[i].e_rv));
            check($sformatf("vec%0d draw_rdata", i), 32'(draw_rdata), 32'(vecs[i].e_rd));
            check($sformatf("vec%0d render_complete", i), 32'(render_complete), 32'(vecs[i].e_rc));
            check($sformatf("vec%0d frame_count", i), 32'(frame_count), 32'(vecs[i].e_fc));
            $display("vec %0d: req=%b we=%b (%0d,%0d) done=%b nf=%b -> buf_we=%b (%0d,%0d) grant=%b rvalid=%b rdata=%0h rc=%b fc=%0d",
                     i, vecs[i].req, vecs[i].we, vecs[i].x, vecs[i].y, vecs[i].done, vecs[i].nf,
                     buf_we, buf_x, buf_y, draw_grant, draw_rvalid, draw_rdata, render_complete, frame_count);
        end

        // Swap with clear enabled: new full clear, frame_count 2.
        set_idle();
        next_frame = 1'b1; clear_enable = 1'b1;
        run_clear(H*V, 16'd2);

        // Reset with a read in flight: outputs drop at once, no read return.
        draw_req = 1'b1; draw_we = 1'b0; draw_x = 10'd3; draw_y = 10'd2;
        @(posedge clock);
        #2;
        reset = 1'b1;
        set_idle();
        #1;
        check_reset_values("async reset in draw");
        repeat (2) begin
            @(negedge clock);
            check("reset draw_rvalid", 32'(draw_rvalid), 0);
        end
        $display("reset during draw: read discarded");
        reset = 1'b0;

        // Reset at clear cycle 17, then the clear restarts from (0,0).
        run_clear(18, 16'd0);
        #1;
        reset = 1'b1;
        #1;
        check("mid-clear reset buf_x", 32'(buf_x), 0);
        check("mid-clear reset buf_y", 32'(buf_y), 0);
        check("mid-clear reset buf_we", 32'(buf_we), 0);
        $display("reset during clear cycle 17: outputs returned to reset values");
        @(negedge clock);
        reset = 1'b0;
        run_clear(H*V, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
